sync_fifo_ext: RTL and testbench

SYNC_FIFO_EXT -- requirements
Module: sync_fifo_ext

---
 rtl/sync_fifo_pkg.sv | 21 ++
 rtl/sync_fifo_ram.sv | 35 +++
 rtl/sync_fifo_ext.sv | 142 ++++++++++++++
 tb/tb_sync_fifo_ext.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg
// Shared definitions for the sync_fifo_ext slice:
//   fifo_mode_e        - read-side behaviour (registered or first-word-fall-through)
//   DEFAULT_DATA_WIDTH - default word width
//   DEFAULT_DEPTH      - default number of entries
//   is_pow2()          - elaboration-time helper for depth checking
package sync_fifo_pkg;

    typedef enum logic {
        MODE_STD  = 1'b0,
        MODE_FWFT = 1'b1
    } fifo_mode_e;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH      = 16;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram
// Storage array for sync_fifo_ext: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
// Ports:
//   clk   - clock, write on rising edge
//   we    - write enable
//   waddr - write index
//   wdata - write word
//   raddr - read index
//   rdata - read word (combinational from raddr)
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]      rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ext.sv
// sync_fifo_ext
// Synchronous FIFO with status/threshold flags, sticky error flags and a
// selectable read mode (registered or first-word-fall-through).
// Ports:
//   clk          - clock, all logic on rising edge
//   rst          - synchronous active-high reset
//   wr_en        - write request (accepted when not full)
//   wr_data      - write word
//   rd_en        - read / pop request (accepted when not empty)
//   rd_data      - read word
//   rd_valid     - rd_data qualifier
//   full, empty  - occupancy status
//   almost_full  - count >= AF_THRESH
//   almost_empty - count <= AE_THRESH
//   count        - occupancy 0..DEPTH
//   overflow     - sticky: write attempted while full
//   underflow    - sticky: read attempted while empty
//   clr_err      - clears overflow/underflow (new events win)
module sync_fifo_ext
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter fifo_mode_e  MODE       = MODE_STD,
    parameter int unsigned AF_THRESH  = DEPTH - 2,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Parameter sanity checks
    if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
        $error("sync_fifo_ext: DEPTH must be a power of two and >= 4");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH - 1) begin : g_bad_af
        $error("sync_fifo_ext: AF_THRESH must be within 1..DEPTH-1");
    end
    if (AE_THRESH < 1 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_ext: AE_THRESH must be within 1..DEPTH-1");
    end

    localparam logic [AW:0] AF_LVL = AF_THRESH[AW:0];
    localparam logic [AW:0] AE_LVL = AE_THRESH[AW:0];

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [AW:0]           wptr;
    logic [AW:0]           rptr;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign empty        = (wptr == rptr);
    assign full         = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count        = wptr - rptr;
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);

    // Acceptance depends only on current flags, so a same-cycle read cannot
    // make room for a write on full, nor a write feed a read on empty
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wptr[AW-1:0]),
        .wdata (wr_data),
        .raddr (rptr[AW-1:0]),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_acc) begin
                rptr <= rptr + 1'b1;
            end
            // A new error event outranks a simultaneous clear
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    if (MODE == MODE_FWFT) begin : g_fwft
        // Head word is always on the output; rd_en only pops
        assign rd_data  = ram_rdata;
        assign rd_valid = !empty;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] rd_data_q;
        logic                  rd_valid_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) begin
                    rd_data_q <= ram_rdata;
                end
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_sync_fifo_ext.sv
// tb_sync_fifo_ext
// Self-checking bench for sync_fifo_ext: one registered-mode instance driven
// against a queue-based occupancy model and read scoreboard, plus one
// first-word-fall-through instance exercised by hand-written sequences.
module tb_sync_fifo_ext;
    import sync_fifo_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Registered-mode instance
    logic          s_wr_en, s_rd_en, s_clr_err;
    logic [DW-1:0] s_wr_data, s_rd_data;
    logic          s_rd_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic [CW-1:0] s_count;

    // FWFT instance
    logic          f_wr_en, f_rd_en, f_clr_err;
    logic [DW-1:0] f_wr_data, f_rd_data;
    logic          f_rd_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [CW-1:0] f_count;

    sync_fifo_ext #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .MODE       (MODE_STD),
        .AF_THRESH  (DEPTH - 2),
        .AE_THRESH  (2)
    ) dut_std (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (s_wr_en),
        .wr_data      (s_wr_data),
        .rd_en        (s_rd_en),
        .rd_data      (s_rd_data),
        .rd_valid     (s_rd_valid),
        .full         (s_full),
        .empty        (s_empty),
        .almost_full  (s_af),
        .almost_empty (s_ae),
        .count        (s_count),
        .overflow     (s_ovf),
        .underflow    (s_udf),
        .clr_err      (s_clr_err)
    );

    sync_fifo_ext #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .MODE       (MODE_FWFT),
        .AF_THRESH  (DEPTH - 2),
        .AE_THRESH  (2)
    ) dut_fwft (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (f_wr_en),
        .wr_data      (f_wr_data),
        .rd_en        (f_rd_en),
        .rd_data      (f_rd_data),
        .rd_valid     (f_rd_valid),
        .full         (f_full),
        .empty        (f_empty),
        .almost_full  (f_af),
        .almost_empty (f_ae),
        .count        (f_count),
        .overflow     (f_ovf),
        .underflow    (f_udf),
        .clr_err      (f_clr_err)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Model of the registered-mode instance
    logic [DW-1:0] m_store[$];   // words held in the FIFO
    logic [DW-1:0] exp_rd[$];    // scoreboard: accepted reads awaiting rd_valid
    int            m_count = 0;
    bit            m_ovf = 0, m_udf = 0;
    logic [DW-1:0] m_rd_data = '0;

    task automatic check_std();
        bit exp_valid;
        exp_valid = (exp_rd.size() != 0);
        chk("count",        s_count,    m_count);
        chk("full",         s_full,     m_count == DEPTH);
        chk("empty",        s_empty,    m_count == 0);
        chk("almost_full",  s_af,       m_count >= DEPTH - 2);
        chk("almost_empty", s_ae,       m_count <= 2);
        chk("overflow",     s_ovf,      m_ovf);
        chk("underflow",    s_udf,      m_udf);
        chk("rd_valid",     s_rd_valid, exp_valid);
        if (exp_valid) m_rd_data = exp_rd.pop_front();
        chk("rd_data",      s_rd_data,  m_rd_data);
    endtask

    // One clock of stimulus on the registered-mode instance, then check
    task automatic step(input bit wr, input logic [DW-1:0] d, input bit rd,
                        input bit clr, input bit do_rst = 1'b0);
        s_wr_en = wr; s_wr_data = d; s_rd_en = rd; s_clr_err = clr; rst = do_rst;
        if (do_rst) begin
            m_store.delete(); exp_rd.delete();
            m_ovf = 0; m_udf = 0; m_rd_data = '0;
        end else begin
            bit wa, ra;
            wa = wr && (m_store.size() < DEPTH);
            ra = rd && (m_store.size() > 0);
            if (wr && m_store.size() == DEPTH) m_ovf = 1;
            else if (clr) m_ovf = 0;
            if (rd && m_store.size() == 0) m_udf = 1;
            else if (clr) m_udf = 0;
            if (ra) exp_rd.push_back(m_store.pop_front());
            if (wa) m_store.push_back(d);
        end
        m_count = m_store.size();
        @(posedge clk); #1;
        s_wr_en = 0; s_rd_en = 0; s_clr_err = 0; rst = 0;
        check_std();
    endtask

    task automatic fstep(input bit wr, input logic [DW-1:0] d, input bit rd);
        f_wr_en = wr; f_wr_data = d; f_rd_en = rd;
        @(posedge clk); #1;
        f_wr_en = 0; f_rd_en = 0;
    endtask

    typedef struct {
        bit            wr;
        logic [DW-1:0] d;
        bit            rd;
        bit            clr;
        int            e_count;
        bit            e_valid;
        logic [DW-1:0] e_data;
        bit            e_udf;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1, 8'h11, 0, 0, 1, 0, 8'h00, 0};
        tbl[1] = '{1, 8'h22, 0, 0, 2, 0, 8'h00, 0};
        tbl[2] = '{1, 8'h33, 1, 0, 2, 1, 8'h11, 0};
        tbl[3] = '{0, 8'h00, 1, 0, 1, 1, 8'h22, 0};
        tbl[4] = '{0, 8'h00, 1, 0, 0, 1, 8'h33, 0};
        tbl[5] = '{0, 8'h00, 1, 0, 0, 0, 8'h33, 1};
        tbl[6] = '{0, 8'h00, 0, 1, 0, 0, 8'h33, 0};
        tbl[7] = '{0, 8'h00, 0, 0, 0, 0, 8'h33, 0};

        s_wr_en = 0; s_rd_en = 0; s_clr_err = 0; s_wr_data = '0;
        f_wr_en = 0; f_rd_en = 0; f_clr_err = 0; f_wr_data = '0;
        rst = 1;

        // Reset state
        step(0, 0, 0, 0, 1);
        chk("rst_empty",  s_empty, 1);
        chk("rst_ae",     s_ae,    1);
        chk("rst_fwft_empty", f_empty, 1);
        chk("rst_fwft_valid", f_rd_valid, 0);

        // Table-driven basic traffic
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].wr, tbl[i].d, tbl[i].rd, tbl[i].clr);
            chk("tbl_count", s_count,    tbl[i].e_count);
            chk("tbl_valid", s_rd_valid, tbl[i].e_valid);
            chk("tbl_data",  s_rd_data,  tbl[i].e_data);
            chk("tbl_udf",   s_udf,      tbl[i].e_udf);
        end

        // Fill to full, then overflow
        for (int i = 0; i < 16; i++) begin
            step(1, DW'(i), 0, 0);
            chk("fill_af", s_af, (i + 1) >= 14);
        end
        chk("fill_full",  s_full,  1);
        chk("fill_count", s_count, 16);
        step(1, 8'hEE, 0, 0);
        chk("ovf_set",    s_ovf,   1);
        chk("ovf_count",  s_count, 16);

        // Drain in order, then underflow
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 0);
            chk("drain_data", s_rd_data, DW'(i));
        end
        step(0, 0, 1, 0);
        chk("udf_set",   s_udf,      1);
        chk("udf_valid", s_rd_valid, 0);
        step(0, 0, 0, 1);

        // Steady count 8 with simultaneous traffic across pointer wraps
        for (int i = 0; i < 8; i++) step(1, DW'(8'h40 + i), 0, 0);
        for (int i = 0; i < 40; i++) begin
            step(1, DW'(8'h80 + i), 1, 0);
            chk("wrap_count", s_count, 8);
        end
        for (int i = 0; i < 9; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 1);

        // Full with simultaneous read and write
        for (int i = 0; i < 16; i++) step(1, DW'(8'hC0 + i), 0, 0);
        step(1, 8'hAB, 1, 0);
        chk("fullrw_count", s_count, 15);
        chk("fullrw_ovf",   s_ovf,   1);

        // New overflow event outranks clr_err
        step(1, 8'hCD, 0, 1);
        step(1, 8'hCE, 0, 1);
        chk("clr_prio_ovf", s_ovf, 1);
        step(0, 0, 0, 1);
        chk("clr_ovf", s_ovf, 0);
        step(1, 8'hCF, 0, 0);

        // Reset with count 5 and overflow set discards everything
        for (int i = 0; i < 11; i++) step(0, 0, 1, 0);
        chk("pre_rst_count", s_count, 5);
        chk("pre_rst_ovf",   s_ovf,   1);
        step(0, 0, 0, 0, 1);
        chk("post_rst_count", s_count,    0);
        chk("post_rst_ovf",   s_ovf,      0);
        chk("post_rst_valid", s_rd_valid, 0);
        step(0, 0, 1, 0);
        chk("post_rst_udf",   s_udf,      1);

        // FWFT behaviour
        fstep(1, 8'hA5, 0);
        chk("fwft_valid", f_rd_valid, 1);
        chk("fwft_data",  f_rd_data,  8'hA5);
        chk("fwft_count", f_count,    1);
        fstep(0, 0, 0);
        chk("fwft_hold",  f_rd_data,  8'hA5);
        fstep(0, 0, 1);
        chk("fwft_pop_empty", f_empty,    1);
        chk("fwft_pop_valid", f_rd_valid, 0);
        fstep(1, 8'h10, 0);
        fstep(1, 8'h20, 0);
        fstep(1, 8'h30, 0);
        chk("fwft_head0", f_rd_data, 8'h10);
        fstep(0, 0, 1);
        chk("fwft_head1", f_rd_data, 8'h20);
        fstep(1, 8'h40, 1);
        chk("fwft_head2", f_rd_data, 8'h30);
        chk("fwft_rw_count", f_count, 2);
        fstep(0, 0, 1);
        fstep(0, 0, 1);
        chk("fwft_empty", f_empty, 1);
        fstep(0, 0, 1);
        chk("fwft_udf", f_udf, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
